rll27_decoder: RTL and testbench

Downstream companion of the RLL(2,7) encoder: receives the channel stream one code bit per strobe, undoes NRZI, parses variable-length (2,7) code words and recovers the original serial data bits. Decoded bits are buffered in a small bit FIFO and delivered serially with a valid/ready handshake. Code-word framing is established at reset, and an illegal pattern forces a resync.

---
 rtl/rll27_decoder.sv | 170 +++++++++++++++++
 tb/tb_rll27_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rll27_decoder.sv
//==============================================================================
// Module   : rll27_decoder
// Purpose  : RLL(2,7) channel decoder: NRZI removal, code-word parsing and a
//            serial bit FIFO with valid/ready output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rll27_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter bit NRZI       = 1'b1
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic chan_i,
    input  logic chan_valid_i,
    output logic data_o,
    output logic data_valid_o,
    input  logic data_ready_i,
    output logic err_o,
    output logic ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

    // Parser state
    logic       r_prev;
    logic [7:0] r_sr;
    logic [3:0] r_cnt;
    logic       r_wr_en;
    logic [2:0] r_wr_len;
    logic [3:0] r_wr_data;
    logic       r_err;

    logic       w_code_bit;
    logic [7:0] w_sr_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_match;
    logic       w_err;
    logic [2:0] w_len;
    logic [3:0] w_data;

    // Decoded word is left-aligned in w_data: first data bit at bit 3
    always_comb begin
        w_code_bit = NRZI ? (chan_i ^ r_prev) : chan_i;
        w_sr_nxt   = {r_sr[6:0], w_code_bit};
        w_cnt_nxt  = r_cnt + 4'd1;
        w_match    = 1'b0;
        w_err      = 1'b0;
        w_len      = 3'd0;
        w_data     = 4'd0;
        case (w_cnt_nxt)
            4'd2: w_err = (w_sr_nxt[1:0] == 2'b11);
            4'd4: begin
                case (w_sr_nxt[3:0])
                    4'b0100: begin w_match = 1'b1; w_len = 3'd2; w_data = 4'b1000; end
                    4'b1000: begin w_match = 1'b1; w_len = 3'd2; w_data = 4'b1100; end
                    4'b0000, 4'b0001, 4'b0010, 4'b1001: ;
                    default: w_err = 1'b1;
                endcase
            end
            4'd6: begin
                case (w_sr_nxt[5:0])
                    6'b000100: begin w_match = 1'b1; w_len = 3'd3; w_data = 4'b0000; end
                    6'b100100: begin w_match = 1'b1; w_len = 3'd3; w_data = 4'b0100; end
                    6'b001000: begin w_match = 1'b1; w_len = 3'd3; w_data = 4'b0110; end
                    6'b001001, 6'b000010: ;
                    default: w_err = 1'b1;
                endcase
            end
            4'd8: begin
                case (w_sr_nxt)
                    8'b00100100: begin w_match = 1'b1; w_len = 3'd4; w_data = 4'b0010; end
                    8'b00001000: begin w_match = 1'b1; w_len = 3'd4; w_data = 4'b0011; end
                    default: w_err = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_prev    <= 1'b0;
            r_sr      <= 8'd0;
            r_cnt     <= 4'd0;
            r_wr_en   <= 1'b0;
            r_wr_len  <= 3'd0;
            r_wr_data <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            if (chan_valid_i) begin
                r_prev    <= chan_i;
                r_wr_en   <= w_match;
                r_wr_len  <= w_len;
                r_wr_data <= w_data;
                r_err     <= w_err;
                if (w_match || w_err) begin
                    r_sr  <= 8'd0;
                    r_cnt <= 4'd0;
                end else begin
                    r_sr  <= w_sr_nxt;
                    r_cnt <= w_cnt_nxt;
                end
            end
        end
    end

    // Bit FIFO
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_occ;
    logic                  r_valid;
    logic                  r_ovf;

    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [AW:0] w_len_ext;
    logic [AW:0] w_free;
    logic [AW:0] w_occ_nxt;

    always_comb begin
        w_len_ext = (AW+1)'(r_wr_len);
        w_pop     = r_valid & data_ready_i;
        w_free    = C_DEPTH - r_occ;
        // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help
        w_push    = r_wr_en & (w_free >= w_len_ext);
        w_drop    = r_wr_en & ~w_push;
        w_occ_nxt = r_occ + (w_push ? w_len_ext : '0) - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) < r_wr_len) begin
                        r_mem[r_wr_ptr + AW'(i)] <= r_wr_data[3-i];
                    end
                end
                r_wr_ptr <= r_wr_ptr + AW'(r_wr_len);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
            r_ovf   <= r_ovf | w_drop;
        end
    end

    assign data_o       = r_mem[r_rd_ptr];
    assign data_valid_o = r_valid;
    assign err_o        = r_err;
    assign ovf_o        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_rll27_decoder.sv
//==============================================================================
// Module   : tb_rll27_decoder
// Purpose  : Scoreboard bench for rll27_decoder (NRZI and raw instances).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rll27_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic n_chan, n_cv, n_rdy, n_data, n_val, n_err, n_ovf;
    logic r_chan, r_cv, r_rdy, r_data, r_val, r_err, r_ovf;

    rll27_decoder #(.FIFO_DEPTH(8), .NRZI(1'b1)) u_nrzi (
        .clk_i(clk), .arst_i(rst), .chan_i(n_chan), .chan_valid_i(n_cv),
        .data_o(n_data), .data_valid_o(n_val), .data_ready_i(n_rdy),
        .err_o(n_err), .ovf_o(n_ovf)
    );

    rll27_decoder #(.FIFO_DEPTH(8), .NRZI(1'b0)) u_raw (
        .clk_i(clk), .arst_i(rst), .chan_i(r_chan), .chan_valid_i(r_cv),
        .data_o(r_data), .data_valid_o(r_val), .data_ready_i(r_rdy),
        .err_o(r_err), .ovf_o(r_ovf)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int err_n  = 0;
    int err_r  = 0;
    bit q_n[$];
    bit q_r[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected bits on every accepted output
    always @(negedge clk) begin
        if (n_err) err_n++;
        if (r_err) err_r++;
        if (!rst && n_val && n_rdy) begin
            if (q_n.size() == 0) check("nrzi unexpected data", 1, 0);
            else check("nrzi data", int'(n_data), int'(q_n.pop_front()));
        end
        if (!rst && r_val && r_rdy) begin
            if (q_r.size() == 0) check("raw unexpected data", 1, 0);
            else check("raw data", int'(r_data), int'(q_r.pop_front()));
        end
    end

    task automatic send_n(input bit b);
        n_chan = b; n_cv = 1'b1;
        @(posedge clk); #1;
        n_cv = 1'b0;
    endtask

    task automatic send_r(input bit b);
        r_chan = b; r_cv = 1'b1;
        @(posedge clk); #1;
        r_cv = 1'b0;
    endtask

    task automatic send_r_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_r(bits[i]);
    endtask

    task automatic push_r(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) q_r.push_back(bits[i]);
    endtask

    task automatic drain_n();
        for (int i = 0; i < 200 && q_n.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("nrzi drain left", q_n.size(), 0);
    endtask

    task automatic drain_r();
        for (int i = 0; i < 200 && q_r.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("raw drain left", q_r.size(), 0);
    endtask

    int e0;

    initial begin
        rst = 1'b1;
        n_chan = 1'b0; n_cv = 1'b0; n_rdy = 1'b1;
        r_chan = 1'b0; r_cv = 1'b0; r_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_o", int'(r_data), 0);
        check("reset valid", int'(r_val), 0);
        check("reset err", int'(r_err), 0);
        check("reset ovf", int'(r_ovf), 0);
        check("reset nrzi valid", int'(n_val), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // NRZI levels 0,1,1,1,0,0,0,0 -> code 0100 1000 -> data 10 11
        q_n.push_back(1'b1); q_n.push_back(1'b0);
        q_n.push_back(1'b1); q_n.push_back(1'b1);
        send_n(0); send_n(1); send_n(1); send_n(1);
        send_n(0); send_n(0); send_n(0); send_n(0);
        drain_n();
        repeat (2) @(posedge clk);
        #1;
        check("nrzi err count", err_n, 0);
        check("nrzi ovf", int'(n_ovf), 0);
        check("nrzi valid idle", int'(n_val), 0);

        // 8-bit words with gapped strobes -> 0010 0011
        push_r(32'b0010_0011, 8);
        for (int i = 7; i >= 0; i--) begin
            send_r(8'b00100100 >> i);
            @(posedge clk); #1;
        end
        for (int i = 7; i >= 0; i--) begin
            send_r(8'b00001000 >> i);
            @(posedge clk); #1;
        end
        drain_r();
        repeat (2) @(posedge clk);
        #1;
        check("8-bit err count", err_r, 0);
        check("8-bit valid idle", int'(r_val), 0);

        // 6-bit words 100100 001000 000100 -> 010 011 000
        push_r(32'b010_011_000, 9);
        send_r_bits(32'b100100_001000_000100, 18);
        drain_r();
        check("6-bit err count", err_r, 0);

        // "11" error, then 0100 -> 10, with latency check
        e0 = err_r;
        send_r(1); send_r(1);
        check("err pulse", int'(r_err), 1);
        check("no data after 11", int'(r_val), 0);
        @(posedge clk); #1;
        check("err one cycle", int'(r_err), 0);
        push_r(32'b10, 2);
        send_r_bits(32'b0100, 4);
        check("latency valid low", int'(r_val), 0);
        @(posedge clk); #1;
        check("latency valid high", int'(r_val), 1);
        check("latency first bit", int'(r_data), 1);
        drain_r();
        check("11 err count", err_r - e0, 1);

        // Overflow: five 0100 words with ready low
        r_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send_r_bits(32'b0100, 4);
        repeat (3) @(posedge clk);
        #1;
        check("ovf set", int'(r_ovf), 1);
        check("full valid", int'(r_val), 1);
        check("hold data", int'(r_data), 1);
        for (int i = 0; i < 4; i++) push_r(32'b10, 2);
        r_rdy = 1'b1;
        drain_r();
        repeat (3) @(posedge clk);
        #1;
        check("ovf drained valid", int'(r_val), 0);
        check("ovf sticky", int'(r_ovf), 1);

        // Reset mid-word discards partial bits
        send_r_bits(32'b001, 3);
        rst = 1'b1;
        #2;
        check("arst data", int'(r_data), 0);
        check("arst valid", int'(r_val), 0);
        check("arst ovf", int'(r_ovf), 0);
        check("arst err", int'(r_err), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        e0 = err_r;
        push_r(32'b11, 2);
        send_r_bits(32'b1000, 4);
        drain_r();
        check("post-reset err", err_r - e0, 0);

        // 0011 is illegal at the fourth bit
        e0 = err_r;
        send_r_bits(32'b0011, 4);
        repeat (3) @(posedge clk);
        #1;
        check("0011 err count", err_r - e0, 1);
        check("0011 no data", int'(r_val), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
